alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Front-end controller for the ALU datapath and its result multiplexer (add/sub/mul/Res/compare selected by a 4-bit op code). Accepts one operation request at a time over a valid/ready handshake and drives operands and op code into the datapath. Start-pulses and waits on the multi-cycle multiplier and Res units, with timeout protection. Registers the selected result and returns it over a valid/ready response handshake.

Parameters:
N, 16, operand/result width (matches ALU datapath width)
TIMEOUT, 64, max cycles spent waiting on mul_done/res_done before error response (>=2)
ERRW, 8, width of saturating error counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept request
req_op  input  4  op code: 0000 add, 0001 sub, 0010 mul, 0011 Res, 0100 compare
req_a  input  N  operand A
req_b  input  N  operand B
opa  output  N  operand A to datapath (registered)
opb  output  N  operand B to datapath (registered)
alu_op  output  4  op code to result mux (registered)
mul_start  output  1  one-cycle start pulse to multiplier
mul_done  input  1  multiplier result valid on mux input this cycle
res_start  output  1  one-cycle start pulse to Res unit
res_done  input  1  Res result valid on mux input this cycle
mux_result  input  N  result mux output
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  N  captured result
rsp_err  output  1  illegal op or timeout
busy  output  1  high in any state other than IDLE
err_count  output  ERRW  saturating count of error responses

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE; opa, opb, rsp_data = 0; alu_op = 0000; mul_start, res_start, rsp_valid, rsp_err, busy = 0; err_count = 0; timeout counter = 0. Reset overrides any state, aborting in-flight ops; no response is issued for an aborted op.
- req_ready = 1 only in IDLE (combinational from state). One op in flight; no overlap.
- States: IDLE, EXEC, WAIT_MUL, WAIT_RES, RESP.
- IDLE: on req_valid, latch req_a->opa, req_b->opb, req_op->alu_op. Next state:
  - 0000/0001/0100 -> EXEC
  - 0010 -> WAIT_MUL
  - 0011 -> WAIT_RES
  - any other op -> RESP with rsp_data=0, rsp_err=1
- EXEC (exactly 1 cycle): at end of cycle, capture mux_result -> rsp_data, rsp_err=0, go to RESP. Accept at edge T gives rsp_valid high from edge T+2.
- WAIT_MUL / WAIT_RES:
  - mul_start (resp. res_start) high only in the first cycle of the state.
  - done is sampled in every cycle of the state, including the start cycle. On done: capture mux_result, rsp_err=0, go to RESP.
  - Timeout counter clears on entry and increments each cycle without done. If the TIMEOUT-th wait cycle ends without done: rsp_data=0, rsp_err=1, go to RESP.
  - done is ignored in all other states; a done for the other unit is ignored.
- RESP: rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready. On rsp_valid&&rsp_ready: rsp_valid=0, go to IDLE. The next request can be accepted the cycle after the handshake.
- opa, opb and alu_op hold their values from acceptance until the next acceptance.
- err_count increments by 1 on entry to RESP with rsp_err=1 and saturates at all-ones.
- Compare result arrives from the mux zero-extended; captured as-is.

Test Plan:
- Add: req_op=0000, a=0x0005, b=0x0003, mux_result=0x0008 -> alu_op=0000; rsp_valid rises 2 cycles after accept; rsp_data=0x0008, rsp_err=0; req_ready low until the cycle after the rsp handshake.
- Mul with latency: req_op=0010, a=0x0010, b=0x0004; mul_done asserted 5 cycles after mul_start with mux_result=0x0040 -> mul_start high exactly 1 cycle; rsp_data=0x0040, rsp_err=0.
- Zero-latency Res: res_done=1 in the same cycle as res_start, mux_result=0x0002 -> RESP next cycle, rsp_data=0x0002.
- Timeout: req_op=0010, mul_done never asserted (TIMEOUT=64) -> rsp_valid after 64 wait cycles; rsp_data=0, rsp_err=1, err_count=1. A late mul_done in RESP/IDLE has no effect.
- Illegal op 0111 -> RESP next cycle with rsp_err=1, rsp_data=0. Hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable throughout. 256 errors with ERRW=8 -> err_count saturates at 0xFF.
- Reset mid-op: assert rst during WAIT_RES -> next cycle IDLE, req_ready=1, rsp_valid=0, alu_op=0000, no response emitted.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for the ALU datapath: accepts one op request, starts and waits on
// the multi-cycle units with timeout protection, and returns the selected result.
module alu_op_sequencer #(
    parameter int unsigned N       = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ERRW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [N-1:0]    req_a,
    input  logic [N-1:0]    req_b,
    output logic [N-1:0]    opa,
    output logic [N-1:0]    opb,
    output logic [3:0]      alu_op,
    output logic            mul_start,
    input  logic            mul_done,
    output logic            res_start,
    input  logic            res_done,
    input  logic [N-1:0]    mux_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [N-1:0]    rsp_data,
    output logic            rsp_err,
    output logic            busy,
    output logic [ERRW-1:0] err_count
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        WAIT_MUL,
        WAIT_RES,
        RESP
    } state_t;

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t        state, state_next;
    logic [TW-1:0] tcnt;
    logic          accept, cap_ok, cap_err, tcnt_inc, done_sel, tmo;

    assign tmo = (tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cap_ok     = 1'b0;
        cap_err    = 1'b0;
        tcnt_inc   = 1'b0;
        req_ready  = (state == IDLE);
        busy       = (state != IDLE);
        rsp_valid  = (state == RESP);
        // The wait counter is zero only in the first cycle of a wait state.
        mul_start  = (state == WAIT_MUL) && (tcnt == '0);
        res_start  = (state == WAIT_RES) && (tcnt == '0);
        done_sel   = (state == WAIT_MUL) ? mul_done : res_done;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    case (req_op)
                        4'b0000, 4'b0001, 4'b0100: state_next = EXEC;
                        4'b0010:                   state_next = WAIT_MUL;
                        4'b0011:                   state_next = WAIT_RES;
                        default: begin
                            state_next = RESP;
                            cap_err    = 1'b1;
                        end
                    endcase
                end
            end
            EXEC: begin
                cap_ok     = 1'b1;
                state_next = RESP;
            end
            WAIT_MUL, WAIT_RES: begin
                if (done_sel) begin
                    cap_ok     = 1'b1;
                    state_next = RESP;
                end else if (tmo) begin
                    cap_err    = 1'b1;
                    state_next = RESP;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            opa       <= '0;
            opb       <= '0;
            alu_op    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            err_count <= '0;
            tcnt      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                opa    <= req_a;
                opb    <= req_b;
                alu_op <= req_op;
                tcnt   <= '0;
            end else if (tcnt_inc) begin
                tcnt <= tcnt + TW'(1);
            end
            if (cap_ok) begin
                rsp_data <= mux_result;
                rsp_err  <= 1'b0;
            end else if (cap_err) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
                if (err_count != '1) err_count <= err_count + ERRW'(1);
            end
        end
    end

endmodule
